sipo_deserializer: RTL and testbench
====================================

SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning the word width in bits, legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: frame-start strobe.
REQ-005 The block SHALL have port msb_first, input, 1 bit: bit order for the frame (1 = MSB first, 0 = LSB first).
REQ-006 The block SHALL have port sin, input, 1 bit: serial data bit.
REQ-007 The block SHALL have port sin_valid, input, 1 bit: sin carries a valid bit this cycle.
REQ-008 The block SHALL have port OUT, output, N bits: last completed parallel word, registered.
REQ-009 The block SHALL have port out_valid, output, 1 bit: one-cycle pulse marking a new word on OUT.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-011 The block SHALL have port bit_cnt, output, ceil(log2(N+1)) bits: number of bits accepted in the current frame.

Function
REQ-012 The block SHALL implement two states: IDLE and RECV; busy SHALL be 1 exactly in RECV.
REQ-013 In IDLE, start=1 SHALL move to RECV, clear bit_cnt to 0, clear the shift register, and latch msb_first into an internal order flag held for the whole frame.
REQ-014 sin and sin_valid SHALL be ignored in IDLE and in the cycle start is sampled.
REQ-015 In RECV, each edge with sin_valid=1 SHALL accept one bit and increment bit_cnt; sin_valid=0 SHALL hold shift register and bit_cnt unchanged (gaps allowed, no timeout).
REQ-016 With order flag=1, accepting a bit SHALL shift as shreg <= {shreg[N-2:0], sin}.
REQ-017 With order flag=0, accepting a bit SHALL shift as shreg <= {sin, shreg[N-1:1]}.
REQ-018 On the edge accepting the Nth bit, OUT SHALL load the completed word (including that bit), out_valid SHALL be 1 in the following cycle, bit_cnt SHALL return to 0, and the state SHALL return to IDLE.
REQ-019 out_valid SHALL be high for exactly one cycle per completed word; OUT SHALL hold its value until the next completed word.
REQ-020 start=1 while in RECV SHALL abort the current frame without asserting out_valid, leave OUT unchanged, and restart per REQ-013 (re-latching msb_first).
REQ-021 start=1 coinciding with acceptance of the Nth bit SHALL complete the word per REQ-018 and then enter RECV with bit_cnt=0 instead of IDLE (back-to-back frames, zero idle cycles).
REQ-022 Changes of msb_first during RECV SHALL have no effect on the current frame.
REQ-023 Latency SHALL be exactly one cycle from the edge sampling the Nth valid bit to out_valid=1.

Reset
REQ-024 rst=1 at a rising edge SHALL force IDLE, OUT=0, out_valid=0, busy=0, bit_cnt=0, shift register=0, order flag=1, with priority over start and sin_valid.
REQ-025 rst asserted mid-frame SHALL discard the partial word with no out_valid pulse; after release the block SHALL require a new start.

Verification (N=8)
REQ-026 Reset, start with msb_first=1, 8 consecutive valid bits 0,0,0,0,1,1,1,1 -> OUT=8'h0F, out_valid high one cycle after 8th bit, busy low afterwards.
REQ-027 Start with msb_first=0, bits 0,1,1,0,0,0,0,0 with sin_valid=0 gaps of 1-3 cycles between bits -> OUT=8'h06, bit_cnt increments only on valid bits.
REQ-028 msb_first=1 frame, after 4 bits assert start with msb_first=0, then send 0,0,1,0,0,0,0,0 -> no pulse for aborted frame, OUT=8'h04.
REQ-029 Two msb_first=1 frames back-to-back, start coincident with 8th bit of first (8'h14 then 8'hA5) -> OUT=8'h14 then 8'hA5, two separate out_valid pulses, busy stays high between frames.
REQ-030 Complete frame 8'h0F, then new frame, assert rst after 5 bits -> OUT=0, out_valid never pulses, busy=0, bit_cnt=0; sin_valid pulses without start after reset produce no change.

Source files
------------

// File: rtl/sipo_deserializer.sv
// Serial-in / parallel-out deserializer: collects N framed bits (MSB- or LSB-first)
// into a word, with frame abort, back-to-back frames and a one-cycle completion pulse.
module sipo_deserializer #(
    parameter int N = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     msb_first,
    input  logic                     sin,
    input  logic                     sin_valid,
    output logic [N-1:0]             OUT,
    output logic                     out_valid,
    output logic                     busy,
    output logic [$clog2(N+1)-1:0]   bit_cnt
);

    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    typedef enum logic {IDLE, RECV} state_t;

    state_t       state;
    logic         order;
    logic [N-1:0] shreg;
    logic [N-1:0] shifted;

    function automatic logic [N-1:0] shift_in(input logic [N-1:0] word,
                                              input logic         b,
                                              input logic         msb);
        if (msb)
            return {word[N-2:0], b};
        return {b, word[N-1:1]};
    endfunction

    assign shifted = shift_in(shreg, sin, order);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            OUT       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            bit_cnt   <= '0;
            shreg     <= '0;
            order     <= 1'b1;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RECV;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                        shreg   <= '0;
                        order   <= msb_first;
                    end
                end
                RECV: begin
                    // Completion wins over start: a coincident start only chains the next frame.
                    if (sin_valid && bit_cnt == LAST) begin
                        OUT       <= shifted;
                        out_valid <= 1'b1;
                        bit_cnt   <= '0;
                        shreg     <= '0;
                        if (start) begin
                            order <= msb_first;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (start) begin
                        bit_cnt <= '0;
                        shreg   <= '0;
                        order   <= msb_first;
                    end else if (sin_valid) begin
                        shreg   <= shifted;
                        bit_cnt <= bit_cnt + ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer (N=8): directed frames plus random traffic, checked
// against a bit-list reference model with a queue of expected completed words.
module tb_sipo_deserializer;

    localparam int N  = 8;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          msb_first = 1'b0;
    logic          sin = 1'b0;
    logic          sin_valid = 1'b0;
    logic [N-1:0]  out_word;
    logic          out_valid;
    logic          busy;
    logic [CW-1:0] bit_cnt;

    sipo_deserializer #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .msb_first (msb_first),
        .sin       (sin),
        .sin_valid (sin_valid),
        .OUT       (out_word),
        .out_valid (out_valid),
        .busy      (busy),
        .bit_cnt   (bit_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: received bits of the open frame, frame order, last word.
    bit           m_busy  = 1'b0;
    bit           m_order = 1'b1;
    bit           m_pulse = 1'b0;
    bit           m_bits[$];
    logic [N-1:0] m_out   = '0;
    logic [N-1:0] exp_q[$];
    bit           mon_en  = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    endfunction

    function automatic logic [N-1:0] assemble(input bit msb);
        logic [N-1:0] w = '0;
        for (int i = 0; i < N; i++) begin
            if (m_bits[i]) begin
                if (msb) w = w + (N'(1) << (N - 1 - i));
                else     w = w + (N'(1) << i);
            end
        end
        return w;
    endfunction

    function automatic void model_step(input bit r, input bit st, input bit mf, input bit s, input bit sv);
        m_pulse = 1'b0;
        if (r) begin
            m_busy  = 1'b0;
            m_order = 1'b1;
            m_out   = '0;
            m_bits.delete();
        end else if (!m_busy) begin
            if (st) begin
                m_busy  = 1'b1;
                m_order = mf;
                m_bits.delete();
            end
        end else if (sv && m_bits.size() == N - 1) begin
            m_bits.push_back(s);
            m_out = assemble(m_order);
            exp_q.push_back(m_out);
            m_pulse = 1'b1;
            m_bits.delete();
            m_busy = st;
            if (st) m_order = mf;
        end else if (st) begin
            m_order = mf;
            m_bits.delete();
        end else if (sv) begin
            m_bits.push_back(s);
        end
    endfunction

    task automatic step(input bit r, input bit st, input bit mf, input bit s, input bit sv);
        rst = r; start = st; msb_first = mf; sin = s; sin_valid = sv;
        @(posedge clk);
        model_step(r, st, mf, s, sv);
        @(negedge clk);
    endtask

    task automatic send_word(input logic [N-1:0] w, input bit msb, input bit start_on_last, input bit next_mf);
        for (int i = 0; i < N; i++) begin
            bit b = msb ? w[N-1-i] : w[i];
            bit last = (i == N - 1);
            step(1'b0, start_on_last && last, next_mf, b, 1'b1);
        end
    endtask

    // Scoreboard monitor: compares every cycle, pops expected words on pulses.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("bit_cnt", 32'(bit_cnt), 32'(m_bits.size()));
            chk("out_valid", 32'(out_valid), 32'(m_pulse));
            chk("out_hold", 32'(out_word), 32'(m_out));
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0)
                    chk("unexpected_pulse", 32'(out_word), 32'hDEAD_BEEF);
                else
                    chk("word", 32'(out_word), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        logic [7:0] w27;
        logic [7:0] w28;
        @(negedge clk);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("reset_out", 32'(out_word), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_cnt", 32'(bit_cnt), 32'h0);

        // Basic MSB-first frame
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        send_word(8'h0F, 1'b1, 1'b0, 1'b0);
        chk("f26_out", 32'(out_word), 32'h0F);
        chk("f26_pulse", 32'(out_valid), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("f26_busy_after", 32'(busy), 32'h0);
        chk("f26_pulse_once", 32'(out_valid), 32'h0);

        // LSB-first frame with gaps
        w27 = 8'b0000_0110;
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < N; i++) begin
            int gap = $urandom_range(1, 3);
            for (int g = 0; g < gap; g++)
                step(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'b0);
            step(1'b0, 1'b0, 1'($urandom), w27[i], 1'b1);
        end
        chk("f27_out", 32'(out_word), 32'h06);

        // Abort after 4 bits, restart LSB-first
        w28 = 8'h04;
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'(i != 1), 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("f28_abort_cnt", 32'(bit_cnt), 32'h0);
        chk("f28_abort_out", 32'(out_word), 32'h06);
        send_word(w28, 1'b0, 1'b0, 1'b1);
        chk("f28_out", 32'(out_word), 32'h04);

        // Back-to-back frames
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        send_word(8'h14, 1'b1, 1'b1, 1'b1);
        chk("f29_first", 32'(out_word), 32'h14);
        chk("f29_busy_between", 32'(busy), 32'h1);
        send_word(8'hA5, 1'b1, 1'b0, 1'b0);
        chk("f29_second", 32'(out_word), 32'hA5);
        chk("f29_pulse", 32'(out_valid), 32'h1);

        // Reset mid-frame
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        send_word(8'h0F, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("f30_out", 32'(out_word), 32'h0);
        chk("f30_busy", 32'(busy), 32'h0);
        chk("f30_cnt", 32'(bit_cnt), 32'h0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'($urandom), 1'b1);
        chk("f30_idle_cnt", 32'(bit_cnt), 32'h0);
        chk("f30_idle_busy", 32'(busy), 32'h0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            bit r  = ($urandom_range(0, 199) == 0);
            bit st = ($urandom_range(0, 24) == 0) || (!m_busy && $urandom_range(0, 3) == 0);
            step(r, st, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) != 0));
        end
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b0;
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
